// File: rtl/miner_csr_if.sv
// Avalon-MM slave bus between the HPS lightweight bridge and the miner CSR block.
interface miner_csr_if #(
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/miner_csr.sv
// Register slave feeding header/difficulty/nonce/control into sha3_256_miner,
// capturing its solution on IRQ and counting run cycles for hash-rate reporting.
module miner_csr #(
  parameter logic [31:0] ID_VALUE = 32'h5348_4133,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic          clk,
  input  logic          rst,
  miner_csr_if.slave    avs,
  output logic [255:0]  header,
  output logic [255:0]  difficulty,
  output logic [63:0]   start_nonce,
  output logic [18:0]   control,
  input  logic [63:0]   solution_in,
  input  logic [2:0]    status_in,
  input  logic          miner_irq_in,
  output logic          irq_out
);

  localparam int unsigned MAP_W = 5;

  logic [7:0][31:0] hdr_q;
  logic [7:0][31:0] dif_q;
  logic [1:0][31:0] nonce_q;
  logic [18:0]      control_q;
  logic [63:0]      sol_q;
  logic [63:0]      runcnt_q;
  logic             irq_en_q;
  logic             irq_pend_q;
  logic             wr_err_q;
  logic             miner_irq_q;

  logic [ADDR_W-1:0] addr_c;
  logic [MAP_W-1:0]  waddr_c;
  logic [31:0]       wdata_c;
  logic              wr_c;
  logic              rd_c;
  logic              miner_rise_c;
  logic              clr_pend_c;
  logic              run_start_c;
  logic [31:0]       rd_data_c;

  assign addr_c       = avs.avs_address;
  assign waddr_c      = MAP_W'(addr_c);
  assign wdata_c      = avs.avs_writedata;
  assign wr_c         = avs.avs_write;
  // A write in the same cycle as a read wins; the read is dropped.
  assign rd_c         = avs.avs_read & ~avs.avs_write;
  assign miner_rise_c = miner_irq_in & ~miner_irq_q;
  assign clr_pend_c   = wr_c & (waddr_c == 5'h17) & wdata_c[0];
  assign run_start_c  = wr_c & (waddr_c == 5'h12) & wdata_c[0] & ~control_q[0];

  assign header      = hdr_q;
  assign difficulty  = dif_q;
  assign start_nonce = nonce_q;
  assign control     = control_q;

  // Read data mux over the word map
  always_comb begin
    rd_data_c = '0;
    case (waddr_c) inside
      [5'h00:5'h07]: rd_data_c = hdr_q[waddr_c[2:0]];
      [5'h08:5'h0F]: rd_data_c = dif_q[waddr_c[2:0]];
      5'h10, 5'h11:  rd_data_c = nonce_q[waddr_c[0]];
      5'h12:         rd_data_c = 32'(control_q);
      5'h13:         rd_data_c = {27'b0, wr_err_q, irq_pend_q, status_in};
      5'h14:         rd_data_c = sol_q[31:0];
      5'h15:         rd_data_c = sol_q[63:32];
      5'h16:         rd_data_c = {31'b0, irq_en_q};
      5'h18:         rd_data_c = runcnt_q[31:0];
      5'h19:         rd_data_c = runcnt_q[63:32];
      5'h1A:         rd_data_c = ID_VALUE;
      default:       rd_data_c = '0;
    endcase
  end

  // Register file writes; parameter words are frozen while the miner runs
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q     <= '0;
      dif_q     <= '0;
      nonce_q   <= '0;
      control_q <= '0;
      irq_en_q  <= 1'b0;
      wr_err_q  <= 1'b0;
    end else if (wr_c) begin
      case (waddr_c) inside
        [5'h00:5'h07]: begin
          if (control_q[0]) wr_err_q <= 1'b1;
          else              hdr_q[waddr_c[2:0]] <= wdata_c;
        end
        [5'h08:5'h0F]: begin
          if (control_q[0]) wr_err_q <= 1'b1;
          else              dif_q[waddr_c[2:0]] <= wdata_c;
        end
        5'h10, 5'h11: begin
          if (control_q[0]) wr_err_q <= 1'b1;
          else              nonce_q[waddr_c[0]] <= wdata_c;
        end
        5'h12: control_q <= wdata_c[18:0];
        5'h16: irq_en_q  <= wdata_c[0];
        5'h17: if (wdata_c[1]) wr_err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Solution capture on miner IRQ rising edge; capture beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      miner_irq_q <= 1'b0;
      sol_q       <= '0;
      irq_pend_q  <= 1'b0;
      irq_out     <= 1'b0;
    end else begin
      miner_irq_q <= miner_irq_in;
      irq_out     <= irq_pend_q & irq_en_q;
      if (miner_rise_c) begin
        sol_q      <= solution_in;
        irq_pend_q <= 1'b1;
      end else if (clr_pend_c) begin
        irq_pend_q <= 1'b0;
      end
    end
  end

  // Run-cycle counter: cleared on run start, frozen while a solution is held
  always_ff @(posedge clk) begin
    if (rst) begin
      runcnt_q <= '0;
    end else if (run_start_c) begin
      runcnt_q <= '0;
    end else if (control_q[0] && !miner_irq_in) begin
      runcnt_q <= runcnt_q + 64'd1;
    end
  end

  // One-cycle registered read response
  always_ff @(posedge clk) begin
    if (rst) begin
      avs.avs_readdata      <= '0;
      avs.avs_readdatavalid <= 1'b0;
    end else begin
      avs.avs_readdatavalid <= rd_c;
      if (rd_c) avs.avs_readdata <= rd_data_c;
    end
  end

endmodule

// File: tb/tb_miner_csr.sv
// Self-checking bench for miner_csr: directed scenarios plus randomized register
// traffic compared against a word-map model of the CSR block.
module tb_miner_csr;

  localparam logic [31:0] ID = 32'h5348_4133;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  miner_csr_if bus ();

  logic [255:0] header;
  logic [255:0] difficulty;
  logic [63:0]  start_nonce;
  logic [18:0]  control;
  logic [63:0]  solution_in;
  logic [2:0]   status_in;
  logic         miner_irq_in;
  logic         irq_out;

  miner_csr dut (
    .clk          (clk),
    .rst          (rst),
    .avs          (bus.slave),
    .header       (header),
    .difficulty   (difficulty),
    .start_nonce  (start_nonce),
    .control      (control),
    .solution_in  (solution_in),
    .status_in    (status_in),
    .miner_irq_in (miner_irq_in),
    .irq_out      (irq_out)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the software-visible register map
  logic [31:0] m_word [0:17];
  logic [18:0] m_ctrl;
  logic        m_en;
  logic        m_pend;
  logic        m_err;
  logic [63:0] m_sol;
  logic [63:0] m_runcnt;

  task automatic model_reset();
    for (int i = 0; i < 18; i++) m_word[i] = '0;
    m_ctrl = '0; m_en = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    m_sol = '0; m_runcnt = '0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a <= 5'h11) return m_word[a];
    case (a)
      5'h12: return {13'b0, m_ctrl};
      5'h13: return {27'b0, m_err, m_pend, status_in};
      5'h14: return m_sol[31:0];
      5'h15: return m_sol[63:32];
      5'h16: return {31'b0, m_en};
      5'h18: return m_runcnt[31:0];
      5'h19: return m_runcnt[63:32];
      5'h1A: return ID;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [4:0] a, input logic [31:0] d);
    if (a <= 5'h11) begin
      if (m_ctrl[0]) m_err = 1'b1;
      else           m_word[a] = d;
    end else begin
      case (a)
        5'h12: m_ctrl = d[18:0];
        5'h16: m_en = d[0];
        5'h17: begin
          if (d[0]) m_pend = 1'b0;
          if (d[1]) m_err = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(posedge clk); #1;
    bus.avs_write     = 1'b0;
    m_write(a, d);
  endtask

  task automatic bus_rd_chk(input string tag, input logic [4:0] a);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(posedge clk); #1;
    bus.avs_read    = 1'b0;
    chk({tag, "_valid"}, 256'(bus.avs_readdatavalid), 256'(1'b1));
    chk(tag, 256'(bus.avs_readdata), 256'(exp_rd(a)));
  endtask

  task automatic chk_outs(input string tag);
    logic [255:0] eh, ed;
    for (int i = 0; i < 8; i++) begin
      eh[i*32 +: 32] = m_word[i];
      ed[i*32 +: 32] = m_word[8+i];
    end
    chk({tag, "_header"}, header, eh);
    chk({tag, "_difficulty"}, difficulty, ed);
    chk({tag, "_nonce"}, 256'(start_nonce), 256'({m_word[17], m_word[16]}));
    chk({tag, "_control"}, 256'(control), 256'(m_ctrl));
  endtask

  initial begin
    logic [4:0]  ra;
    logic [31:0] rd;

    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    solution_in = '0; status_in = '0; miner_irq_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_outs_header", header, '0);
    chk("rst_control", 256'(control), '0);
    chk("rst_irq_out", 256'(irq_out), '0);
    chk("rst_rdvalid", 256'(bus.avs_readdatavalid), '0);
    bus_rd_chk("rst_id", 5'h1A);
    chk("rst_id_const", 256'(bus.avs_readdata), 256'(32'h5348_4133));
    bus_rd_chk("rst_ctrl", 5'h12);
    bus_rd_chk("rst_runcnt", 5'h18);

    // Header and nonce programming
    for (int i = 0; i < 8; i++) bus_wr(5'(i), 32'(i + 1));
    bus_wr(5'h10, 32'd5);
    bus_wr(5'h11, 32'd0);
    chk("t2_header", header, {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
    chk("t2_nonce", 256'(start_nonce), 256'(64'd5));
    bus_rd_chk("t2_rd_hdr3", 5'h03);

    // Randomized register traffic against the model
    repeat (80) begin
      status_in = 3'($urandom);
      ra = 5'($urandom_range(0, 31));
      rd = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        bus_wr(ra, rd);
        chk_outs("rand_wr");
      end else if (ra != 5'h18 && ra != 5'h19) begin
        bus_rd_chk("rand_rd", ra);
      end
    end

    // Write lock while running
    bus_wr(5'h12, 32'h1);
    bus_wr(5'h00, 32'hFFFF);
    chk_outs("t3_locked");
    bus_rd_chk("t3_status_err", 5'h13);
    bus_wr(5'h17, 32'h2);
    bus_rd_chk("t3_status_clr", 5'h13);

    // Solution capture and interrupt
    bus_wr(5'h16, 32'h1);
    solution_in  = 64'h1234;
    miner_irq_in = 1'b1;
    @(posedge clk); #1;
    m_pend = 1'b1; m_sol = solution_in;
    chk("t4_irq_lag", 256'(irq_out), '0);
    miner_irq_in = 1'b0;
    @(posedge clk); #1;
    chk("t4_irq_set", 256'(irq_out), 256'(1'b1));
    bus_rd_chk("t4_sol_lo", 5'h14);
    bus_rd_chk("t4_status", 5'h13);
    bus_wr(5'h17, 32'h1);
    @(posedge clk); #1;
    chk("t4_irq_clr", 256'(irq_out), '0);

    // Clear colliding with a new capture: capture wins
    solution_in = {$urandom, $urandom};
    bus.avs_address = 5'h17; bus.avs_writedata = 32'h1; bus.avs_write = 1'b1;
    miner_irq_in = 1'b1;
    @(posedge clk); #1;
    bus.avs_write = 1'b0;
    m_pend = 1'b1; m_sol = solution_in;
    bus_rd_chk("t5_status", 5'h13);
    bus_rd_chk("t5_sol_hi", 5'h15);
    miner_irq_in = 1'b0;
    bus_wr(5'h17, 32'h1);
    bus_rd_chk("t5_status_clr", 5'h13);

    // Run-cycle counter
    solution_in = 64'hCAFE_0000_BEEF;
    bus_wr(5'h12, 32'h0);
    bus_wr(5'h12, 32'h1);
    repeat (100) @(posedge clk);
    #1 miner_irq_in = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    m_pend = 1'b1; m_sol = solution_in; m_runcnt = 64'd100;
    bus_rd_chk("t6_runcnt_lo", 5'h18);
    bus_rd_chk("t6_runcnt_hi", 5'h19);
    bus_rd_chk("t6_sol_lo", 5'h14);

    // Simultaneous read and write: write lands, read dropped
    bus.avs_address = 5'h16; bus.avs_writedata = 32'h0;
    bus.avs_read = 1'b1; bus.avs_write = 1'b1;
    @(posedge clk); #1;
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    m_en = 1'b0;
    chk("t6_rw_novalid", 256'(bus.avs_readdatavalid), '0);
    bus_rd_chk("t6_irq_en", 5'h16);
    chk("t6_irq_masked", 256'(irq_out), '0);

    // Reset mid-operation drops the in-flight read and clears everything
    miner_irq_in = 1'b0;
    bus.avs_address = 5'h1A; bus.avs_read = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    bus.avs_read = 1'b0; rst = 1'b0;
    model_reset();
    chk("mid_rst_valid", 256'(bus.avs_readdatavalid), '0);
    chk_outs("mid_rst");
    chk("mid_rst_irq", 256'(irq_out), '0);
    bus_rd_chk("mid_rst_status", 5'h13);
    bus_rd_chk("mid_rst_sol", 5'h14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
